// File: rtl/wind_meas_sequencer_if.sv
// Sequencer <-> wind datapath / polar converter signal bundle.
interface wind_meas_sequencer_if;
  logic        start;
  logic        continuous;
  logic        res_valid;
  logic [15:0] speed_in;
  logic [15:0] dir_in;
  logic        tx_en;
  logic [3:0]  tx_sel;
  logic        endata;
  logic        dp_clear;
  logic [15:0] speed;
  logic [15:0] direction;
  logic        out_valid;
  logic        busy;
  logic        timeout_err;
  logic [7:0]  meas_count;

  modport slave (
    input  start, continuous, res_valid, speed_in, dir_in,
    output tx_en, tx_sel, endata, dp_clear, speed, direction,
    output out_valid, busy, timeout_err, meas_count
  );

  modport master (
    output start, continuous, res_valid, speed_in, dir_in,
    input  tx_en, tx_sel, endata, dp_clear, speed, direction,
    input  out_valid, busy, timeout_err, meas_count
  );
endinterface

// File: rtl/wind_meas_sequencer.sv
// Ultrasonic wind measurement round scheduler (N,E,S,W firings).
// Optional macro WINDSEQ_RETRY_EN: one automatic retry per round on timeout.
module wind_meas_sequencer #(
  parameter int BURST_CYCLES   = 16,
  parameter int GUARD_CYCLES   = 64,
  parameter int LISTEN_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic clock,
  input logic reset,
  wind_meas_sequencer_if.slave bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] BURST    = 3'd1;
  localparam logic [2:0] GUARD    = 3'd2;
  localparam logic [2:0] LISTEN   = 3'd3;
  localparam logic [2:0] WAIT_RES = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  localparam logic [31:0] B1 = 32'(BURST_CYCLES - 1);
  localparam logic [31:0] G1 = 32'(GUARD_CYCLES - 1);
  localparam logic [31:0] L1 = 32'(LISTEN_CYCLES - 1);
  localparam logic [31:0] T1 = 32'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state;
  logic [31:0] cnt;
  logic [1:0]  idx;
  logic        dp_clear;
  logic        out_valid;
  logic        timeout_err;
  logic [15:0] speed;
  logic [15:0] direction;
  logic [7:0]  meas_count;
`ifdef WINDSEQ_RETRY_EN
  logic        retried;
`endif

  logic firing;
  assign firing = (state == BURST) || (state == GUARD) ||
                  (state == LISTEN);

  assign bus.tx_en       = (state == BURST);
  assign bus.endata      = (state == LISTEN);
  assign bus.tx_sel      = firing ? (4'b0001 << idx) : 4'b0000;
  assign bus.busy        = (state != IDLE);
  assign bus.dp_clear    = dp_clear;
  assign bus.out_valid   = out_valid;
  assign bus.timeout_err = timeout_err;
  assign bus.speed       = speed;
  assign bus.direction   = direction;
  assign bus.meas_count  = meas_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      dp_clear    <= 1'b0;
      out_valid   <= 1'b0;
      timeout_err <= 1'b0;
      speed       <= '0;
      direction   <= '0;
      meas_count  <= '0;
`ifdef WINDSEQ_RETRY_EN
      retried     <= 1'b0;
`endif
    end else begin
      dp_clear  <= 1'b0;
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= BURST;
            idx         <= 2'd0;
            cnt         <= B1;
            dp_clear    <= 1'b1;
            timeout_err <= 1'b0;
`ifdef WINDSEQ_RETRY_EN
            retried     <= 1'b0;
`endif
          end
        end
        BURST: begin
          if (cnt == '0) begin
            state <= GUARD;
            cnt   <= G1;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        GUARD: begin
          if (cnt == '0) begin
            state <= LISTEN;
            cnt   <= L1;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        LISTEN: begin
          if (cnt == '0) begin
            if (idx == 2'd3) begin
              state <= WAIT_RES;
              cnt   <= T1;
            end else begin
              state <= BURST;
              idx   <= idx + 2'd1;
              cnt   <= B1;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        WAIT_RES: begin
          // a result on the final timeout cycle still counts
          if (bus.res_valid) begin
            state      <= DONE;
            speed      <= bus.speed_in;
            direction  <= bus.dir_in;
            out_valid  <= 1'b1;
            meas_count <= meas_count + 8'd1;
          end else if (cnt == '0) begin
`ifdef WINDSEQ_RETRY_EN
            if (!retried) begin
              retried  <= 1'b1;
              state    <= BURST;
              idx      <= 2'd0;
              cnt      <= B1;
              dp_clear <= 1'b1;
            end else begin
              timeout_err <= 1'b1;
              state       <= DONE;
            end
`else
            timeout_err <= 1'b1;
            state       <= DONE;
`endif
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        DONE: begin
          if (bus.continuous) begin
            state    <= BURST;
            idx      <= 2'd0;
            cnt      <= B1;
            dp_clear <= 1'b1;
`ifdef WINDSEQ_RETRY_EN
            retried  <= 1'b0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wind_meas_sequencer.md
Name: wind_meas_sequencer

Overview:
Measurement scheduler for the ultrasonic wind datapath (two wind time-of-flight cores feeding the rectangular-to-polar converter).
- Runs one acquisition round: fires the four transducers in turn, each followed by a listen window during which endata is asserted to the datapath.
- Waits for the polar result, latches speed/direction and reports completion.
- Runs single-shot or free-running, with timeout detection.

Parameters:
BURST_CYCLES, 16, cycles tx_en stays high per firing (>=1)
GUARD_CYCLES, 64, ring-down cycles between burst end and listen start (>=1)
LISTEN_CYCLES, 1024, cycles endata stays high per firing (>=1)
TIMEOUT_CYCLES, 4096, max cycles waiting for res_valid after last listen (>=1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin a round; sampled only in IDLE
continuous  in  1  when high, a new round starts automatically after each round ends
res_valid  in  1  result-valid pulse from the polar converter
speed_in  in  16  magnitude from the converter
dir_in  in  16  angle from the converter
tx_en  out  1  transducer drive enable
tx_sel  out  4  one-hot transducer select: bit0=N(rx1), bit1=E(rx2), bit2=S(rx3), bit3=W(rx4)
endata  out  1  datapath sample enable
dp_clear  out  1  one-cycle clear pulse to the datapath at round start
speed  out  16  latched speed
direction  out  16  latched direction
out_valid  out  1  one-cycle pulse when speed/direction update
busy  out  1  high in every state except IDLE
timeout_err  out  1  sticky timeout flag
meas_count  out  8  completed-round counter

Behaviour:
- Reset values (one cycle after reset is sampled, including mid-round): all outputs 0; state IDLE; tx_sel=0000.
- States: IDLE, BURST, GUARD, LISTEN, WAIT_RES, DONE. A single down-counter times each state; a 2-bit index selects the transducer.
- IDLE: when start=1, go to BURST with index=0. dp_clear pulses in the first BURST cycle of every round.
- BURST: tx_en=1, tx_sel=one-hot(index), for exactly BURST_CYCLES cycles, then GUARD.
- GUARD: tx_en=0, tx_sel held, for GUARD_CYCLES cycles, then LISTEN.
- LISTEN: endata=1, tx_sel held, for LISTEN_CYCLES cycles.
  - If index<3: increment index and go to BURST.
  - If index=3: go to WAIT_RES.
- Firing order per round: N, E, S, W. Total cycles from the first BURST cycle to WAIT_RES entry = 4*(BURST_CYCLES+GUARD_CYCLES+LISTEN_CYCLES).
- WAIT_RES: tx_sel=0000, endata=0.
  - On res_valid=1: latch speed_in/dir_in and go to DONE.
  - If TIMEOUT_CYCLES cycles elapse without res_valid: set timeout_err, leave speed/direction unchanged, no out_valid, go to DONE.
  - If res_valid arrives on the same cycle the timeout expires, res_valid wins.
- DONE (one cycle):
  - After a successful round: out_valid=1 and meas_count increments (255 wraps to 0).
  - Then go to BURST (index=0) if continuous=1, else IDLE.
- res_valid outside WAIT_RES is ignored.
- start while busy is ignored.
- timeout_err clears only on reset or on an accepted start.
- speed/direction hold until the next successful latch.

Optional Feature:
WINDSEQ_RETRY_EN:
- Defined: the first timeout in a round does not set timeout_err. The sequencer restarts the same round from BURST index=0 with a fresh dp_clear. A second timeout in that round sets timeout_err and proceeds as normal. The retry budget resets every round.
- Undefined: no retry; a timeout sets the flag immediately.

Test Plan:
- BURST=4, GUARD=2, LISTEN=8, TIMEOUT=20; start pulse; res_valid 5 cycles after WAIT_RES entry with speed_in=0x0A00, dir_in=0x2D00 -> tx_sel sequence 0001/0010/0100/1000, each tx_en 4 cycles and endata 8 cycles; WAIT_RES entered 56 cycles after the first BURST cycle; speed=0x0A00, direction=0x2D00; out_valid one pulse; meas_count=1; busy drops.
- Same parameters, res_valid never arrives -> timeout_err=1 after 20 WAIT_RES cycles; no out_valid; speed/direction keep previous values; next start clears timeout_err. With WINDSEQ_RETRY_EN defined: a full second round runs first, then the flag sets.
- continuous=1 for 3 rounds with res_valid each round -> 3 out_valid pulses; dp_clear pulses 3 times; no IDLE cycle between rounds; meas_count=3.
- res_valid pulsed during LISTEN, and start pulsed during BURST -> both ignored; no latch; no restart.
- reset asserted in the middle of the third LISTEN -> next cycle all outputs 0 and state IDLE; a subsequent start runs a full clean round.
- meas_count preloaded to 255 via 255 rounds (or force) plus one more round -> wraps to 0 together with out_valid.
